// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Two-requester access controller for an 8x8-bit memory array.
//
//   Requesters A and B compete for the array. When both request in the same
//   IDLE cycle, round-robin arbitration picks the one not served last. Each
//   granted access then runs a fixed four-state sequence:
//     IDLE -> SETUP -> ACCESS -> DONE -> IDLE
//   SETUP lets the decoder address settle. ACCESS raises the decoder valid
//   strobe and the write or read enable. DONE pulses the winner's response.
//
// Ports
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_req_x             request from requester x (x = a/b), held until o_gnt_x
//   i_we_x              1 = write, 0 = read
//   i_addr_x            row address
//   i_wdata_x           write data
//   o_gnt_x             request accepted this cycle (combinational, IDLE only)
//   o_rsp_x             one-cycle completion pulse
//   o_rdata             registered read data, shared by both requesters
//   o_k_address         row decoder address
//   o_valid             row decoder valid strobe
//   o_write_en          array write strobe
//   o_read_en           array read strobe
//   o_wdata             array write data
//   i_rdata             array read data, valid while o_read_en is high
module mem_access_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_a,
  input  logic              i_we_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_wdata_a,
  output logic              o_gnt_a,
  output logic              o_rsp_a,
  input  logic              i_req_b,
  input  logic              i_we_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_wdata_b,
  output logic              o_gnt_b,
  output logic              o_rsp_b,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_k_address,
  output logic              o_valid,
  output logic              o_write_en,
  output logic              o_read_en,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [DATA_W-1:0] i_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              gnt_a;
  logic              gnt_b;
  logic              last_b;     // 1: B was served most recently
  logic              lat_we;
  logic              lat_id_b;   // 1: the access in flight belongs to B
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and arbitration. Grants are masked while reset is asserted,
  // so every output is low as soon as reset rises, even with requests pending.
  always_comb begin
    state_nxt = state;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    case (state)
      IDLE: begin
        if (!i_rst) begin
          // A wins when it is alone, or when both request and B went last.
          if (i_req_a && (!i_req_b || last_b)) begin
            gnt_a = 1'b1;
          end else if (i_req_b) begin
            gnt_b = 1'b1;
          end
        end
        if (gnt_a || gnt_b) begin
          state_nxt = SETUP;
        end
      end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request at the grant edge. These registers hold in
  // every other cycle, which keeps the array address and data stable from
  // SETUP through DONE and parked while IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_b    <= 1'b1;
      lat_id_b  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (gnt_a || gnt_b) begin
      last_b    <= gnt_b;
      lat_id_b  <= gnt_b;
      lat_we    <= gnt_a ? i_we_a    : i_we_b;
      lat_addr  <= gnt_a ? i_addr_a  : i_addr_b;
      lat_wdata <= gnt_a ? i_wdata_a : i_wdata_b;
    end
  end

  // Read data is captured at the end of ACCESS, so it is visible during DONE
  // together with the response pulse. Writes leave it untouched.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q <= '0;
    end else if ((state == ACCESS) && !lat_we) begin
      rdata_q <= i_rdata;
    end
  end

  // The strobes are decoded directly from the state register. An asynchronous
  // reset therefore drops them at once, which cuts off an in-flight write.
  assign o_gnt_a     = gnt_a;
  assign o_gnt_b     = gnt_b;
  assign o_valid     = (state == ACCESS);
  assign o_write_en  = (state == ACCESS) &&  lat_we;
  assign o_read_en   = (state == ACCESS) && !lat_we;
  assign o_rsp_a     = (state == DONE) && !lat_id_b;
  assign o_rsp_b     = (state == DONE) &&  lat_id_b;
  assign o_k_address = lat_addr;
  assign o_wdata     = lat_wdata;
  assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [2:0] addr_a = '0, addr_b = '0;
  logic [7:0] wdata_a = '0, wdata_b = '0, rdata_in = '0;
  logic       gnt_a, gnt_b, rsp_a, rsp_b, valid, write_en, read_en;
  logic [2:0] k_address;
  logic [7:0] rdata, wdata;

  int n_checks = 0;
  int n_pass   = 0;

  // {gnt_a, gnt_b, rsp_a, rsp_b, valid, write_en, read_en}
  wire [6:0] ctl = {gnt_a, gnt_b, rsp_a, rsp_b, valid, write_en, read_en};

  mem_access_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_a(req_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_wdata_a(wdata_a),
    .o_gnt_a(gnt_a), .o_rsp_a(rsp_a),
    .i_req_b(req_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_wdata_b(wdata_b),
    .o_gnt_b(gnt_b), .o_rsp_b(rsp_b),
    .o_rdata(rdata), .o_k_address(k_address), .o_valid(valid),
    .o_write_en(write_en), .o_read_en(read_en), .o_wdata(wdata),
    .i_rdata(rdata_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({ctl, k_address, wdata, rdata} !== 26'd0)
      $display("FAIL reset_outputs: got ctl=%b addr=%0d wdata=%h rdata=%h required all 0",
               ctl, k_address, wdata, rdata);
    else n_pass++;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      n_checks++;
      if (ctl !== 7'b0) $display("FAIL reset_idle%0d: got ctl=%b required 0000000", i, ctl);
      else n_pass++;
    end
  endtask

  task automatic test_write_a();
    cyc();
    req_a = 1; we_a = 1; addr_a = 3'd5; wdata_a = 8'hA5; #1;
    n_checks++;
    if (ctl !== 7'b1000000) $display("FAIL wr_a_gnt: got ctl=%b required 1000000", ctl);
    else n_pass++;
    cyc(); req_a = 0; #1;
    n_checks++;
    if ({ctl, k_address, wdata} !== {7'b0, 3'd5, 8'hA5})
      $display("FAIL wr_a_setup: got ctl=%b addr=%0d wdata=%h required 0000000 5 a5", ctl, k_address, wdata);
    else n_pass++;
    cyc(); #1;
    n_checks++;
    if ({ctl, k_address, wdata} !== {7'b0000110, 3'd5, 8'hA5})
      $display("FAIL wr_a_access: got ctl=%b addr=%0d wdata=%h required 0000110 5 a5", ctl, k_address, wdata);
    else n_pass++;
    cyc(); #1;
    n_checks++;
    if (ctl !== 7'b0010000) $display("FAIL wr_a_done: got ctl=%b required 0010000", ctl);
    else n_pass++;
    cyc(); #1;
    n_checks++;
    if ({ctl, k_address} !== {7'b0, 3'd5})
      $display("FAIL wr_a_idle_hold: got ctl=%b addr=%0d required 0000000 5", ctl, k_address);
    else n_pass++;
  endtask

  task automatic test_read_b();
    cyc();
    req_b = 1; we_b = 0; addr_b = 3'd3; wdata_b = 8'h00; #1;
    n_checks++;
    if (ctl !== 7'b0100000) $display("FAIL rd_b_gnt: got ctl=%b required 0100000", ctl);
    else n_pass++;
    cyc(); req_b = 0; #1;
    n_checks++;
    if (ctl !== 7'b0) $display("FAIL rd_b_setup: got ctl=%b required 0000000", ctl);
    else n_pass++;
    cyc(); rdata_in = 8'h3C; #1;
    n_checks++;
    if ({ctl, k_address} !== {7'b0000101, 3'd3})
      $display("FAIL rd_b_access: got ctl=%b addr=%0d required 0000101 3", ctl, k_address);
    else n_pass++;
    cyc(); rdata_in = 8'hFF; #1;
    n_checks++;
    if ({ctl, rdata} !== {7'b0001000, 8'h3C})
      $display("FAIL rd_b_done: got ctl=%b rdata=%h required 0001000 3c", ctl, rdata);
    else n_pass++;
    // A following write must not disturb the read data.
    cyc();
    req_a = 1; we_a = 1; addr_a = 3'd1; wdata_a = 8'h11; #1;
    n_checks++;
    if (ctl !== 7'b1000000) $display("FAIL rd_b_wr_gnt: got ctl=%b required 1000000", ctl);
    else n_pass++;
    cyc(); req_a = 0;
    cyc(); cyc(); #1;
    n_checks++;
    if ({ctl, rdata} !== {7'b0010000, 8'h3C})
      $display("FAIL rd_b_hold: got ctl=%b rdata=%h required 0010000 3c", ctl, rdata);
    else n_pass++;
  endtask

  task automatic test_tie();
    cyc(); rst = 1; #1;
    n_checks++;
    if ({ctl, rdata} !== 15'd0) $display("FAIL tie_rst: got ctl=%b rdata=%h required 0", ctl, rdata);
    else n_pass++;
    cyc();
    rst = 0;
    req_a = 1; we_a = 1; addr_a = 3'd2; wdata_a = 8'h22;
    req_b = 1; we_b = 0; addr_b = 3'd6; rdata_in = 8'h5A;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ctl !== ((i % 2 == 0) ? 7'b1000000 : 7'b0100000))
        $display("FAIL tie_gnt%0d: got ctl=%b required %s", i, ctl, (i % 2 == 0) ? "1000000" : "0100000");
      else n_pass++;
      cyc(); #1;
      n_checks++;
      if (ctl !== 7'b0) $display("FAIL tie_setup%0d: got ctl=%b required 0000000", i, ctl);
      else n_pass++;
      cyc(); #1;
      n_checks++;
      if ((i % 2 == 0) ? ({ctl, k_address} !== {7'b0000110, 3'd2}) : ({ctl, k_address} !== {7'b0000101, 3'd6}))
        $display("FAIL tie_access%0d: got ctl=%b addr=%0d required %s", i, ctl, k_address,
                 (i % 2 == 0) ? "0000110 2" : "0000101 6");
      else n_pass++;
      cyc(); #1;
      n_checks++;
      if (ctl !== ((i % 2 == 0) ? 7'b0010000 : 7'b0001000))
        $display("FAIL tie_done%0d: got ctl=%b required %s", i, ctl, (i % 2 == 0) ? "0010000" : "0001000");
      else n_pass++;
      cyc();
      if (i == 3) begin req_a = 0; req_b = 0; end
      #1;
    end
    n_checks++;
    if (rdata !== 8'h5A) $display("FAIL tie_rdata: got %h required 5a", rdata);
    else n_pass++;
  endtask

  task automatic test_busy_hold();
    cyc();
    req_a = 1; we_a = 1; addr_a = 3'd4; wdata_a = 8'h44; #1;
    n_checks++;
    if (ctl !== 7'b1000000) $display("FAIL busy_gnt_a: got ctl=%b required 1000000", ctl);
    else n_pass++;
    cyc(); req_a = 0; req_b = 1; we_b = 1; addr_b = 3'd0; wdata_b = 8'h00; #1;
    n_checks++;
    if (ctl !== 7'b0) $display("FAIL busy_c1: got ctl=%b required 0000000", ctl);
    else n_pass++;
    cyc(); addr_b = 3'd7; wdata_b = 8'h77; #1;
    n_checks++;
    if ({ctl, k_address} !== {7'b0000110, 3'd4})
      $display("FAIL busy_c2: got ctl=%b addr=%0d required 0000110 4", ctl, k_address);
    else n_pass++;
    cyc(); #1;
    n_checks++;
    if (ctl !== 7'b0010000) $display("FAIL busy_c3: got ctl=%b required 0010000", ctl);
    else n_pass++;
    cyc(); #1;
    n_checks++;
    if (ctl !== 7'b0100000) $display("FAIL busy_c4_gnt_b: got ctl=%b required 0100000", ctl);
    else n_pass++;
    cyc(); req_b = 0;
    cyc(); #1;
    n_checks++;
    if ({ctl, k_address, wdata} !== {7'b0000110, 3'd7, 8'h77})
      $display("FAIL busy_b_access: got ctl=%b addr=%0d wdata=%h required 0000110 7 77", ctl, k_address, wdata);
    else n_pass++;
    cyc(); #1;
    n_checks++;
    if (ctl !== 7'b0001000) $display("FAIL busy_b_done: got ctl=%b required 0001000", ctl);
    else n_pass++;
  endtask

  task automatic test_abort();
    cyc();
    req_a = 1; we_a = 1; addr_a = 3'd5; wdata_a = 8'h5F; #1;
    n_checks++;
    if (ctl !== 7'b1000000) $display("FAIL abort_gnt: got ctl=%b required 1000000", ctl);
    else n_pass++;
    cyc(); req_a = 0;
    cyc(); #1;
    n_checks++;
    if (ctl !== 7'b0000110) $display("FAIL abort_access: got ctl=%b required 0000110", ctl);
    else n_pass++;
    #1 rst = 1; #1;
    n_checks++;
    if ({ctl, k_address, wdata, rdata} !== 26'd0)
      $display("FAIL abort_immediate: got ctl=%b addr=%0d wdata=%h rdata=%h required all 0",
               ctl, k_address, wdata, rdata);
    else n_pass++;
    cyc(); rst = 0; #1;
    n_checks++;
    if (ctl !== 7'b0) $display("FAIL abort_release: got ctl=%b required 0000000", ctl);
    else n_pass++;
    cyc(); #1;
    n_checks++;
    if (ctl !== 7'b0) $display("FAIL abort_no_rsp: got ctl=%b required 0000000", ctl);
    else n_pass++;
    cyc();
    req_a = 1; we_a = 0; addr_a = 3'd1;
    req_b = 1; we_b = 0; addr_b = 3'd2; rdata_in = 8'h81; #1;
    n_checks++;
    if (ctl !== 7'b1000000) $display("FAIL abort_first_gnt: got ctl=%b required 1000000", ctl);
    else n_pass++;
    cyc(); req_a = 0; req_b = 0;
    cyc(); cyc(); #1;
    n_checks++;
    if ({ctl, rdata} !== {7'b0010000, 8'h81})
      $display("FAIL abort_post_read: got ctl=%b rdata=%h required 0010000 81", ctl, rdata);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_b();
    test_tie();
    test_busy_hold();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
